parity_engine: RTL and testbench
================================

// Module: parity_engine
//
// PURPOSE
//   Parametrised parity generator/checker for the UART datapath.
//   - Captures a parallel word on Data_Valid and walks it serially, LSB first, one bit per clk.
//   - Produces the parity bit for a run-time frame length (1..DATA_WIDTH) and one of four parity modes.
//   - Optionally compares the result against a received parity bit, so the same block serves TX generation and RX checking.
//   - Sits between the frame-control FSM and the serializer/deserializer; par_done tells the FSM when parity_bit is usable.
//
// PARAMETERS
//   DATA_WIDTH  8  maximum data bits per frame; width of P_DATA
//   LEN_W       4  width of DATA_LEN; must satisfy 2**LEN_W > DATA_WIDTH
//
// PORTS
//   clk         in   1           system clock, rising edge
//   reset_n     in   1           asynchronous active-low reset
//   Data_Valid  in   1           capture request, honoured only in IDLE
//   P_DATA      in   DATA_WIDTH  parallel data word; bit 0 is sent first
//   DATA_LEN    in   LEN_W       number of valid LSBs in P_DATA
//   PAR_EN      in   1           parity enable; sampled with Data_Valid
//   PAR_MODE    in   2           00 even, 01 odd, 10 mark (1), 11 space (0)
//   CHK_EN      in   1           1: check RX_PAR against computed parity
//   RX_PAR      in   1           received parity bit; sampled with Data_Valid
//   busy        out  1           high in CALC and DONE
//   parity_bit  out  1           computed parity; holds until next DONE
//   par_done    out  1           one-cycle pulse, result valid
//   par_err     out  1           parity mismatch flag; valid from par_done
//
// BEHAVIOUR
//   Reset (async): all outputs 0; state IDLE; shift reg, counter, accumulator cleared.
//   A reset asserted mid-CALC or in DONE aborts immediately. No par_done is generated for the aborted word.
//   FSM states: IDLE -> CALC -> DONE -> IDLE.
//   IDLE:
//     - Data_Valid & PAR_EN: latch P_DATA, PAR_MODE, CHK_EN, RX_PAR and the effective length.
//     - Effective length = DATA_LEN, except DATA_LEN==0 or DATA_LEN>DATA_WIDTH, which clamp to DATA_WIDTH.
//     - Clear the accumulator and counter, then go to CALC.
//     - Data_Valid with PAR_EN=0: ignored. State and all outputs unchanged.
//   CALC:
//     - Each cycle: acc <= acc ^ shreg[0]; shreg >>= 1; cnt++.
//     - Leave for DONE when cnt reaches the effective length. CALC therefore lasts exactly len cycles.
//     - Mark and space modes also run the full count, so latency is uniform across modes.
//   DONE (one cycle):
//     - parity_bit <= even: acc; odd: ~acc; mark: 1; space: 0.
//     - par_done is high for this cycle only.
//     - par_err <= CHK_EN & (new parity_bit != latched RX_PAR).
//     - Next state IDLE.
//   Timing: capture edge is E0; parity_bit, par_done and par_err update at edge E0+len+1.
//   Data_Valid while busy=1 is ignored (no queueing). Minimum accepted spacing is len+2 cycles.
//   parity_bit and par_err hold their values until the next DONE.
//   Mid-operation changes to P_DATA, PAR_MODE, CHK_EN, RX_PAR or DATA_LEN have no effect on the word in flight.
//
// TESTING
//   1. Reset with inputs idle -> busy, parity_bit, par_done, par_err all 0; stay 0 for 20 cycles.
//   2. P_DATA=8'hA5, len 8, even -> par_done 9 cycles after capture; parity_bit=0, par_err=0.
//      Same word, odd -> parity_bit=1.
//   3. P_DATA=8'hFF, DATA_LEN=3, even -> parity_bit=1, par_done at E0+4.
//      DATA_LEN=0 clamps to 8 -> parity_bit=0, par_done at E0+9.
//   4. Mark then space on 8'h00, len 8 -> parity_bit 1 then 0; each par_done at E0+9.
//   5. Check mode: 8'h01, even, CHK_EN=1, RX_PAR=0 -> par_err=1.
//      Repeat with RX_PAR=1 -> par_err=0.
//   6. Data_Valid re-pulsed 3 cycles after capture -> ignored, exactly one par_done.
//      reset_n low at E0+4 -> outputs 0 at once, no par_done follows.

Source files
------------

// File: rtl/parity_engine.sv
// Serial parity generator/checker: captures a word, walks it LSB first and
// produces even/odd/mark/space parity, optionally checked against a received bit.
module parity_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  Data_Valid,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic [LEN_W-1:0]      DATA_LEN,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_MODE,
    input  logic                  CHK_EN,
    input  logic                  RX_PAR,
    output logic                  busy,
    output logic                  parity_bit,
    output logic                  par_done,
    output logic                  par_err
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_WIDTH);

    localparam logic [1:0] MODE_EVEN  = 2'b00;
    localparam logic [1:0] MODE_ODD   = 2'b01;
    localparam logic [1:0] MODE_MARK  = 2'b10;
    localparam logic [1:0] MODE_SPACE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] shreg;
    logic [LEN_W-1:0]      cnt;
    logic [LEN_W-1:0]      cnt_inc;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      eff_len;
    logic [1:0]            mode_q;
    logic                  chk_q;
    logic                  rx_q;
    logic                  acc;
    logic                  capture;
    logic                  new_parity;

    assign cnt_inc = cnt + LEN_W'(1);

    // A zero or oversize length means "use the full word".
    always_comb begin
        eff_len = DATA_LEN;
        if (DATA_LEN == '0 || DATA_LEN > MAX_LEN) begin
            eff_len = MAX_LEN;
        end
    end

    always_comb begin
        new_parity = acc;
        case (mode_q)
            MODE_EVEN:  new_parity = acc;
            MODE_ODD:   new_parity = ~acc;
            MODE_MARK:  new_parity = 1'b1;
            MODE_SPACE: new_parity = 1'b0;
            default:    new_parity = acc;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (Data_Valid && PAR_EN) begin
                    capture    = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt_inc == len_q) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Everything about the word in flight is frozen at capture time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg  <= '0;
            cnt    <= '0;
            len_q  <= '0;
            mode_q <= '0;
            chk_q  <= 1'b0;
            rx_q   <= 1'b0;
            acc    <= 1'b0;
        end else if (capture) begin
            shreg  <= P_DATA;
            cnt    <= '0;
            len_q  <= eff_len;
            mode_q <= PAR_MODE;
            chk_q  <= CHK_EN;
            rx_q   <= RX_PAR;
            acc    <= 1'b0;
        end else if (state == CALC) begin
            acc   <= acc ^ shreg[0];
            shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
            cnt   <= cnt_inc;
        end
    end

    // Results are published on the edge that leaves DONE and held until the next word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_bit <= 1'b0;
            par_done   <= 1'b0;
            par_err    <= 1'b0;
        end else if (state == DONE) begin
            parity_bit <= new_parity;
            par_done   <= 1'b1;
            par_err    <= chk_q & (new_parity != rx_q);
        end else begin
            par_done   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_parity_engine.sv
// Directed self-checking bench for parity_engine: latency, parity modes,
// length clamping, check mode, ignored requests and mid-word reset.
module tb_parity_engine;

    localparam int DATA_WIDTH = 8;
    localparam int LEN_W      = 4;

    logic                  clk;
    logic                  reset_n;
    logic                  Data_Valid;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic [LEN_W-1:0]      DATA_LEN;
    logic                  PAR_EN;
    logic [1:0]            PAR_MODE;
    logic                  CHK_EN;
    logic                  RX_PAR;
    logic                  busy;
    logic                  parity_bit;
    logic                  par_done;
    logic                  par_err;

    int vec_count;
    int err_count;

    parity_engine #(
        .DATA_WIDTH(DATA_WIDTH),
        .LEN_W     (LEN_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Data_Valid(Data_Valid),
        .P_DATA    (P_DATA),
        .DATA_LEN  (DATA_LEN),
        .PAR_EN    (PAR_EN),
        .PAR_MODE  (PAR_MODE),
        .CHK_EN    (CHK_EN),
        .RX_PAR    (RX_PAR),
        .busy      (busy),
        .parity_bit(parity_bit),
        .par_done  (par_done),
        .par_err   (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Presents one request and returns just after the capture edge E0.
    task automatic captureWord(input logic [7:0] data, input logic [3:0] len, input logic [1:0] mode,
                               input logic chk, input logic rx);
        @(negedge clk);
        P_DATA     = data;
        DATA_LEN   = len;
        PAR_MODE   = mode;
        CHK_EN     = chk;
        RX_PAR     = rx;
        PAR_EN     = 1'b1;
        Data_Valid = 1'b1;
        @(posedge clk);
        #1;
        Data_Valid = 1'b0;
    endtask

    // Counts edges after E0 until par_done; -1 if it never comes.
    task automatic waitDone(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (par_done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [7:0] data, input logic [3:0] len,
                                 input logic [1:0] mode, input logic chk, input logic rx,
                                 input int exp_lat, input logic exp_par, input logic exp_err);
        int lat;
        captureWord(data, len, mode, chk, rx);
        // Scramble inputs while the word is in flight; the result must not change.
        P_DATA   = ~data;
        DATA_LEN = 4'd1;
        PAR_MODE = ~mode;
        CHK_EN   = ~chk;
        RX_PAR   = ~rx;
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        waitDone(lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_parity"}, 32'(parity_bit), 32'(exp_par));
        checkOutput({tag, "_err"}, 32'(par_err), 32'(exp_err));
        @(posedge clk);
        #1;
        checkOutput({tag, "_pulse"}, {30'd0, par_done, busy}, 32'd0);
    endtask

    initial begin
        int done_cnt;
        int busy_cnt;
        vec_count  = 0;
        err_count  = 0;
        reset_n    = 1'b0;
        Data_Valid = 1'b0;
        P_DATA     = '0;
        DATA_LEN   = '0;
        PAR_EN     = 1'b0;
        PAR_MODE   = 2'b00;
        CHK_EN     = 1'b0;
        RX_PAR     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("in_reset", {busy, parity_bit, par_done, par_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("idle_%0d", i), {busy, parity_bit, par_done, par_err}, 32'd0);
        end

        // 8'hA5 has four ones.
        applyStimulus("a5_even", 8'hA5, 4'd8, 2'b00, 1'b0, 1'b0, 9, 1'b0, 1'b0);
        applyStimulus("a5_odd",  8'hA5, 4'd8, 2'b01, 1'b0, 1'b0, 9, 1'b1, 1'b0);

        applyStimulus("ff_len3",  8'hFF, 4'd3, 2'b00, 1'b0, 1'b0, 4, 1'b1, 1'b0);
        applyStimulus("ff_len0",  8'hFF, 4'd0, 2'b00, 1'b0, 1'b0, 9, 1'b0, 1'b0);
        applyStimulus("ff_len9",  8'hFF, 4'd9, 2'b00, 1'b0, 1'b0, 9, 1'b0, 1'b0);
        applyStimulus("ff_len1",  8'hFE, 4'd1, 2'b01, 1'b0, 1'b0, 2, 1'b1, 1'b0);

        applyStimulus("mark",  8'h00, 4'd8, 2'b10, 1'b0, 1'b0, 9, 1'b1, 1'b0);
        applyStimulus("space", 8'h00, 4'd8, 2'b11, 1'b0, 1'b0, 9, 1'b0, 1'b0);

        applyStimulus("chk_rx0", 8'h01, 4'd8, 2'b00, 1'b1, 1'b0, 9, 1'b1, 1'b1);
        applyStimulus("chk_rx1", 8'h01, 4'd8, 2'b00, 1'b1, 1'b1, 9, 1'b1, 1'b0);

        // Request without PAR_EN must be ignored entirely.
        @(negedge clk);
        P_DATA     = 8'h00;
        PAR_MODE   = 2'b11;
        PAR_EN     = 1'b0;
        Data_Valid = 1'b1;
        done_cnt   = 0;
        busy_cnt   = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            Data_Valid = 1'b0;
            if (par_done) done_cnt++;
            if (busy) busy_cnt++;
        end
        checkOutput("noen_done", 32'(done_cnt), 32'd0);
        checkOutput("noen_busy", 32'(busy_cnt), 32'd0);
        checkOutput("noen_hold", {30'd0, parity_bit, par_err}, 32'd2);

        // Re-pulse while busy: only the first word completes.
        captureWord(8'h01, 4'd8, 2'b00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        P_DATA     = 8'h03;
        Data_Valid = 1'b1;
        @(posedge clk);
        #1;
        Data_Valid = 1'b0;
        done_cnt   = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (par_done) done_cnt++;
        end
        checkOutput("repulse_done", 32'(done_cnt), 32'd1);
        checkOutput("repulse_parity", 32'(parity_bit), 32'd1);

        // Reset at E0+4 aborts the word and clears the held result.
        captureWord(8'h00, 4'd8, 2'b10, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("abort_outs", {busy, parity_bit, par_done, par_err}, 32'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (par_done) done_cnt++;
        end
        checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
        checkOutput("abort_idle", {busy, parity_bit, par_done, par_err}, 32'd0);

        // 8'h07 has three ones.
        applyStimulus("recover", 8'h07, 4'd8, 2'b00, 1'b0, 1'b0, 9, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
